// File: rtl/cc_nand_share_arbiter.sv
// Round-robin arbiter sharing one registered bitwise-NAND unit among NUM_REQ requesters.
// Each operation runs IDLE -> ISSUE -> RESP; all outputs are registered.
//
//   state | meaning
//   IDLE  | wait for a request, pick the winner from ptr, latch its operands
//   ISSUE | compute the NAND of the latched operands into the result register
//   RESP  | load the one-hot ack, rotate ptr past the winner, bump the op counter
module cc_nand_share_arbiter #(
    parameter int DATA_WIDTH = 1,
    parameter int NUM_REQ    = 4,
    parameter int IDX_WIDTH  = 2,
    parameter int CNT_WIDTH  = 8
) (
    input  logic                          CC_NandArbiter_CLOCK_50,
    input  logic                          CC_NandArbiter_RESET_InHigh,
    input  logic [NUM_REQ-1:0]            CC_NandArbiter_Req_In,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] CC_NandArbiter_A_In,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] CC_NandArbiter_B_In,
    output logic [NUM_REQ-1:0]            CC_NandArbiter_Ack_Out,
    output logic [DATA_WIDTH-1:0]         CC_NandArbiter_Z_Out,
    output logic [IDX_WIDTH-1:0]          CC_NandArbiter_Grant_Out,
    output logic                          CC_NandArbiter_Busy_Out,
    output logic [CNT_WIDTH-1:0]          CC_NandArbiter_OpCount_Out
);

    typedef enum logic [1:0] {IDLE, ISSUE, RESP} stateT;

    stateT                 state, stateNext;
    logic [IDX_WIDTH-1:0]  ptr, ptrNext;
    logic [IDX_WIDTH-1:0]  grantReg, grantNext;
    logic [DATA_WIDTH-1:0] aLat, aNext, bLat, bNext;
    logic [DATA_WIDTH-1:0] zReg, zNext;
    logic [NUM_REQ-1:0]    ackReg, ackNext;
    logic                  busyReg, busyNext;
    logic [CNT_WIDTH-1:0]  opCount, opCountNext;

    logic [IDX_WIDTH-1:0]  pick;
    logic                  pickValid;
    logic [IDX_WIDTH-1:0]  scanIdx;
    logic [DATA_WIDTH-1:0] aSel, bSel;

    // First requester at or after ptr, wrapping modulo NUM_REQ.
    always_comb begin
        pick      = '0;
        pickValid = 1'b0;
        scanIdx   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            scanIdx = IDX_WIDTH'((int'(ptr) + i) % NUM_REQ);
            if (!pickValid && CC_NandArbiter_Req_In[scanIdx]) begin
                pickValid = 1'b1;
                pick      = scanIdx;
            end
        end
    end

    always_comb begin
        aSel = '0;
        bSel = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (pick == IDX_WIDTH'(i)) begin
                aSel = CC_NandArbiter_A_In[i*DATA_WIDTH +: DATA_WIDTH];
                bSel = CC_NandArbiter_B_In[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    always_comb begin
        stateNext   = state;
        ptrNext     = ptr;
        grantNext   = grantReg;
        aNext       = aLat;
        bNext       = bLat;
        zNext       = zReg;
        ackNext     = '0;
        busyNext    = busyReg;
        opCountNext = opCount;
        case (state)
            IDLE: begin
                if (pickValid) begin
                    grantNext = pick;
                    aNext     = aSel;
                    bNext     = bSel;
                    busyNext  = 1'b1;
                    stateNext = ISSUE;
                end
            end
            ISSUE: begin
                zNext     = ~(aLat & bLat);
                stateNext = RESP;
            end
            RESP: begin
                ackNext[grantReg] = 1'b1;
                ptrNext     = (grantReg == IDX_WIDTH'(NUM_REQ - 1)) ? '0
                                                                    : grantReg + IDX_WIDTH'(1);
                opCountNext = opCount + CNT_WIDTH'(1);
                busyNext    = 1'b0;
                stateNext   = IDLE;
            end
            default: begin
                busyNext  = 1'b0;
                stateNext = IDLE;
            end
        endcase
    end

    always_ff @(posedge CC_NandArbiter_CLOCK_50) begin
        if (CC_NandArbiter_RESET_InHigh) begin
            state    <= IDLE;
            ptr      <= '0;
            grantReg <= '0;
            aLat     <= '0;
            bLat     <= '0;
            zReg     <= '0;
            ackReg   <= '0;
            busyReg  <= 1'b0;
            opCount  <= '0;
        end else begin
            state    <= stateNext;
            ptr      <= ptrNext;
            grantReg <= grantNext;
            aLat     <= aNext;
            bLat     <= bNext;
            zReg     <= zNext;
            ackReg   <= ackNext;
            busyReg  <= busyNext;
            opCount  <= opCountNext;
        end
    end

    assign CC_NandArbiter_Ack_Out     = ackReg;
    assign CC_NandArbiter_Z_Out       = zReg;
    assign CC_NandArbiter_Grant_Out   = grantReg;
    assign CC_NandArbiter_Busy_Out    = busyReg;
    assign CC_NandArbiter_OpCount_Out = opCount;

endmodule
